// File: rtl/board_arb_pkg.sv
// Shared definitions for the board RAM arbiter: default RAM geometry,
// the arbiter FSM state type and a one-hot decode helper.
package board_arb_pkg;

    localparam int BOARD_ADDR_W = 5;
    localparam int BOARD_DATA_W = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // One-hot decode of a requester index (up to 8 requesters).
    function automatic logic [7:0] onehot(input logic [2:0] idx);
        logic [7:0] v;
        v      = 8'd0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/board_ram_arbiter_rr_picker.sv
// Combinational find-first-set over the request vector, starting at a
// pointer and wrapping around. With fixed_prio set the search always
// starts at bit 0, giving plain lowest-index priority.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             fixed_prio,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int               base;
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        base     = fixed_prio ? 0 : int'(start);
        cand     = 0;
        cand_idx = '0;
        idx      = '0;
        valid    = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = base + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                idx   = cand_idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/board_ram_arbiter.sv
// Board RAM arbiter: shares the single port of the game-board RAM between
// N_REQ requesters using round-robin selection with a bounded burst.
// Build option: define BOARD_ARB_FIXED_PRIO_EN to make the idle pick use
// lowest-index priority instead of round-robin (same ports and timing).
module board_ram_arbiter
    import board_arb_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = BOARD_ADDR_W,
    parameter int DATA_W    = BOARD_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0]          we_i,
    input  logic [N_REQ*ADDR_W-1:0]   addr_i,
    input  logic [N_REQ*DATA_W-1:0]   wdata_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          rvalid_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic                      ram_we_o,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_wdata_o,
    input  logic [DATA_W-1:0]         ram_rdata_i
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_TOP = BURST_W'(MAX_BURST - 1);

`ifdef BOARD_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_t         state_reg,  state_next;
    logic [IDX_W-1:0]   owner_reg,  owner_next;
    logic [IDX_W-1:0]   last_reg,   last_next;
    logic [BURST_W-1:0] burst_reg,  burst_next;
    logic [N_REQ-1:0]   rvalid_reg, rvalid_next;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];
    logic [7:0]         owner_oh8;
    logic [N_REQ-1:0]   owner_oh;
    logic [IDX_W-1:0]   start_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               access;
    logic               others_waiting;

    // Unpack the per-requester address and write-data slices.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign addr_arr[gi]  = addr_i[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = wdata_i[gi*DATA_W +: DATA_W];
    end

    assign owner_oh8      = onehot(3'(owner_reg));
    assign owner_oh       = owner_oh8[N_REQ-1:0];
    assign start_ptr      = (last_reg == LAST_IDX) ? '0 : last_reg + 1'b1;
    assign access         = (state_reg == BUSY) && req_i[owner_reg];
    assign others_waiting = |(req_i & ~owner_oh);

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req        (req_i),
        .start      (start_ptr),
        .fixed_prio (FIXED_PRIO),
        .idx        (pick_idx),
        .valid      (pick_valid)
    );

    // Next-state logic: pick an owner in IDLE, count and release bursts in BUSY.
    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        burst_next  = burst_reg;
        rvalid_next = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    owner_next = pick_idx;
                    burst_next = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!req_i[owner_reg]) begin
                    last_next  = owner_reg;
                    state_next = IDLE;
                end else begin
                    if (!we_i[owner_reg]) begin
                        rvalid_next = owner_oh;
                    end
                    if (burst_reg == BURST_TOP) begin
                        // Saturate while alone; hand over once someone waits.
                        if (others_waiting) begin
                            last_next  = owner_reg;
                            state_next = IDLE;
                        end
                    end else begin
                        burst_next = burst_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            owner_reg  <= '0;
            last_reg   <= LAST_IDX;
            burst_reg  <= '0;
            rvalid_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            burst_reg  <= burst_next;
            rvalid_reg <= rvalid_next;
        end
    end

    assign gnt_o       = (state_reg == BUSY) ? owner_oh : '0;
    assign ram_we_o    = access && we_i[owner_reg];
    assign ram_addr_o  = access ? addr_arr[owner_reg]  : '0;
    assign ram_wdata_o = access ? wdata_arr[owner_reg] : '0;
    assign rvalid_o    = rvalid_reg;
    assign rdata_o     = (|rvalid_reg) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: table of per-cycle vectors plus
// hand-built sequences for bursts, saturation and reset during a read.
// Read data is tracked by a scoreboard queue fed from a shadow memory.
module tb_board_ram_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 10;

    typedef struct {
        logic          rst_n;
        logic [N-1:0]  req;
        logic [N-1:0]  we;
        logic [N*AW-1:0] addr;
        logic [N*DW-1:0] wdata;
        logic [N-1:0]  exp_gnt;
    } vec_t;

    typedef struct {
        logic [N-1:0]  who;
        logic [DW-1:0] data;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    logic [DW-1:0]   ram_mem [32];
    logic [DW-1:0]   shadow  [32];
    sb_t             sb [$];
    int              n_tests = 0;
    int              n_fail  = 0;

    always #5 clk = ~clk;

    board_ram_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
        .rdata_o(rdata), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // Board RAM model: registered read, 1-cycle latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    function automatic vec_t mk(input logic r, input logic [N-1:0] q,
                                input logic [N-1:0] w, input logic [N*AW-1:0] a,
                                input logic [N*DW-1:0] d, input logic [N-1:0] g);
        vec_t v;
        v.rst_n = r; v.req = q; v.we = w; v.addr = a; v.wdata = d; v.exp_gnt = g;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle (entered at posedge+1), check mid-cycle, advance.
    task automatic run_cycle(input vec_t v, input string name);
        int            own;
        logic          acc, exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata;
        sb_t           e;
        rst_n = v.rst_n; req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
        #4;
        own = 0;
        for (int k = 0; k < N; k++) if (v.exp_gnt[k]) own = k;
        acc       = |(v.req & v.exp_gnt);
        exp_we    = acc && |(v.we & v.exp_gnt);
        exp_addr  = acc ? v.addr[own*AW +: AW]  : '0;
        exp_wdata = acc ? v.wdata[own*DW +: DW] : '0;
        $display("[TB] %s rst_n=%b req=%b we=%b gnt=%b ram_we=%b addr=%0d wdata=%h rvalid=%b rdata=%h",
                 name, v.rst_n, v.req, v.we, gnt, ram_we, ram_addr, ram_wdata, rvalid, rdata);
        check({name, ".gnt"},       32'(gnt),       32'(v.exp_gnt));
        check({name, ".ram_we"},    32'(ram_we),    32'(exp_we));
        check({name, ".ram_addr"},  32'(ram_addr),  32'(exp_addr));
        check({name, ".ram_wdata"}, 32'(ram_wdata), 32'(exp_wdata));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({name, ".rvalid"}, 32'(rvalid), 32'(e.who));
            check({name, ".rdata"},  32'(rdata),  32'(e.data));
        end else begin
            check({name, ".rvalid"}, 32'(rvalid), 32'(0));
        end
        if (acc && !exp_we && v.rst_n) begin
            e.who  = v.exp_gnt;
            e.data = shadow[exp_addr];
            sb.push_back(e);
        end
        if (exp_we) shadow[exp_addr] = exp_wdata;
        @(posedge clk); #1;
    endtask

    task automatic reset_seq(input string name);
        for (int c = 0; c < 3; c++)
            run_cycle(mk(1'b0, 3'b111, 3'b000, '0, '0, 3'b000), $sformatf("%s%0d", name, c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  tbl [13];
        logic [N-1:0] g;
        logic [N-1:0] second;
        rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        @(posedge clk); #1;

        // Reset, single write by req0, read-back by req2, wrap-around to req0.
        tbl[0]  = mk(0, 3'b111, 3'b000, '0, '0, 3'b000);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = mk(1, 3'b111, 3'b001, {5'd0, 5'd0, 5'd7}, {10'h0, 10'h0, 10'h2A5}, 3'b000);
        tbl[4]  = mk(1, 3'b001, 3'b001, {5'd0, 5'd0, 5'd7}, {10'h0, 10'h0, 10'h2A5}, 3'b001);
        tbl[5]  = mk(1, 3'b000, 3'b001, {5'd0, 5'd0, 5'd7}, {10'h0, 10'h0, 10'h2A5}, 3'b001);
        tbl[6]  = mk(1, 3'b100, 3'b000, {5'd7, 5'd0, 5'd0}, {10'h3FF, 10'h0, 10'h0}, 3'b000);
        tbl[7]  = mk(1, 3'b100, 3'b000, {5'd7, 5'd0, 5'd0}, {10'h3FF, 10'h0, 10'h0}, 3'b100);
        tbl[8]  = mk(1, 3'b000, 3'b000, {5'd7, 5'd0, 5'd0}, {10'h3FF, 10'h0, 10'h0}, 3'b100);
        tbl[9]  = mk(1, 3'b101, 3'b000, {5'd7, 5'd0, 5'd7}, {10'h3FF, 10'h0, 10'h0}, 3'b000);
        tbl[10] = mk(1, 3'b101, 3'b000, {5'd7, 5'd0, 5'd7}, {10'h3FF, 10'h0, 10'h0}, 3'b001);
        tbl[11] = mk(1, 3'b000, 3'b000, {5'd7, 5'd0, 5'd7}, {10'h3FF, 10'h0, 10'h0}, 3'b001);
        tbl[12] = mk(1, 3'b000, 3'b000, '0, '0, 3'b000);
        for (int i = 0; i < 13; i++) run_cycle(tbl[i], $sformatf("tbl%0d", i));

        // Burst limit: req0 writes, req1 reads addr 7, both held.
`ifdef BOARD_ARB_FIXED_PRIO_EN
        second = 3'b001;
`else
        second = 3'b010;
`endif
        reset_seq("brst_rst");
        for (int c = 0; c < 18; c++) begin
            if (c % 5 == 0 || c == 17) g = 3'b000;
            else g = ((c / 5) % 2 == 1) ? second : 3'b001;
            run_cycle(mk(1, (c < 16) ? 3'b011 : 3'b000, 3'b001,
                         {5'd0, 5'd7, 5'(10 + c % 8)},
                         {10'h0, 10'h0, 10'(c * 13 + 1)}, g),
                      $sformatf("burst%0d", c));
        end

        // Saturation: only req1, alternating read/write on addr 7, no dead cycle.
        for (int c = 0; c < 23; c++) begin
            g = (c == 0 || c == 22) ? 3'b000 : 3'b010;
            run_cycle(mk(1, (c < 21) ? 3'b010 : 3'b000, {1'b0, 1'(c % 2), 1'b0},
                         {5'd0, 5'd7, 5'd0}, {10'h0, 10'(c * 37), 10'h0}, g),
                      $sformatf("sat%0d", c));
        end

        // Reset arriving at the edge that ends a read: no rvalid afterwards.
        run_cycle(mk(1, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, '0, 3'b000), "midrd0");
        run_cycle(mk(0, 3'b001, 3'b000, {5'd0, 5'd0, 5'd7}, '0, 3'b001), "midrd1");
        run_cycle(mk(0, 3'b000, 3'b000, '0, '0, 3'b000), "midrd2");
        run_cycle(mk(1, 3'b000, 3'b000, '0, '0, 3'b000), "midrd3");
        // After reset requester 0 wins over requester 2.
        run_cycle(mk(1, 3'b101, 3'b101, {5'd3, 5'd0, 5'd4}, {10'h111, 10'h0, 10'h155}, 3'b000), "wrap0");
        run_cycle(mk(1, 3'b101, 3'b101, {5'd3, 5'd0, 5'd4}, {10'h111, 10'h0, 10'h155}, 3'b001), "wrap1");
        run_cycle(mk(1, 3'b000, 3'b000, '0, '0, 3'b001), "wrap2");
        run_cycle(mk(1, 3'b000, 3'b000, '0, '0, 3'b000), "wrap3");

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/board_ram_arbiter.md
Name: board_ram_arbiter

Overview:
- Shares the single write/read port of the game-board RAM (32 cells × 10 bits) between several requesters, such as the token generator, the move engine and the display scanner.
- Uses round-robin arbitration with a bounded burst length.
- Drives the RAM address, write-enable and write-data signals, and returns read data to the owning requester with a 1-cycle RAM latency.
- Sits between the requester blocks and the board RAM instance.

Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 5, board RAM address width
- DATA_W, 10, board RAM data width
- MAX_BURST, 4, maximum consecutive accesses by one owner while another requester is waiting

Ports:
- clk_i  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- req_i  in  N_REQ  per-requester access request; held until served
- we_i  in  N_REQ  per-requester write (1) / read (0) select
- addr_i  in  N_REQ*ADDR_W  packed addresses; requester k uses slice k
- wdata_i  in  N_REQ*DATA_W  packed write data
- gnt_o  out  N_REQ  one-hot grant
- rvalid_o  out  N_REQ  read-data-valid pulse for requester k
- rdata_o  out  DATA_W  read data (shared), valid when any rvalid_o bit is set
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data; registered in the RAM, 1-cycle latency

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, ram_we_o=0, ram_addr_o=0, ram_wdata_o=0.
  - last_q=N_REQ-1, so requester 0 wins first. burst_cnt=0.
  - A read in flight when reset asserts is discarded; no rvalid is produced.
- FSM with 2 states:
  - IDLE: gnt_o=0. If any req_i bit is set, owner_q <= first requester with req set, searching from (last_q+1) mod N_REQ with wrap-around. Then state <= BUSY and burst_cnt <= 0. Arbitration latency is 1 cycle from req to gnt.
  - BUSY: gnt_o = onehot(owner_q).
- Access rule: an access happens in every BUSY cycle where req_i[owner] is 1.
  - ram_addr_o and ram_wdata_o come combinationally from the owner's slices.
  - ram_we_o = we_i[owner].
  - On a read, rvalid_o[owner]=1 exactly one cycle later, with rdata_o = ram_rdata_i in that cycle.
  - If there is no access, the RAM outputs are 0.
- Release conditions in BUSY:
  - req_i[owner]=0: no access this cycle. last_q <= owner, state <= IDLE.
  - An access with burst_cnt==MAX_BURST-1 while another req_i bit is set: the access completes, then last_q <= owner and state <= IDLE.
  - If no other requester is waiting, burst_cnt saturates at MAX_BURST-1 and the owner keeps the grant indefinitely.
  - Otherwise burst_cnt increments on each access.
- A release always passes through one IDLE cycle, so there is exactly one dead cycle between owners.
- req or we changes on a non-owner while BUSY have no effect.
- When the owner's we_i toggles between cycles, each cycle's access is independent; read/write back-to-back is allowed.
- Only the owner can receive rvalid. A read issued in the owner's last cycle still returns rvalid during the following IDLE cycle.

Optional Feature:
- Macro BOARD_ARB_FIXED_PRIO_EN.
- Defined: the IDLE pick ignores last_q and always selects the lowest-index requesting bit. MAX_BURST release still applies, and the released owner re-competes, so a lower index can win again.
- Undefined: round-robin as described above.
- Ports and timing are identical in both builds.

Decomposition:
- Package board_arb_pkg holds:
  - localparams BOARD_ADDR_W=5 and BOARD_DATA_W=10
  - typedef enum logic {IDLE, BUSY} arb_state_t
  - a function onehot(idx)
- Sub-module rr_picker: combinational find-first-set over N_REQ bits, starting from a pointer with wrap-around. Outputs an index plus a valid bit. It takes a fixed_prio input, tied according to the macro.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_i=3'b111 → gnt_o=0, all RAM outputs 0. After release, gnt_o=3'b001 on the second edge.
- Single writer: req0 with we=1, addr=5'd7, wdata=10'h2A5 → ram_we_o=1, ram_addr_o=7, ram_wdata_o=0x2A5 while gnt_o=001. A subsequent read by req2 of addr 7 → rvalid_o=100 one cycle after its access, rdata_o=0x2A5.
- Burst limit: req0 and req1 held continuously → req0 gets 4 accesses, then 1 IDLE cycle, then req1 gets 4, then req0. Never more than 4 consecutive accesses.
- Saturation: only req1 held for 20 cycles → gnt_o stays 010 for all 20 cycles with no dead cycle.
- Wrap-around: last owner=2, with req0 and req2 pending → req0 is granted next (and req2 is granted again under BOARD_ARB_FIXED_PRIO_EN only if req0 is absent).
- Reset mid-read: owner issues a read, rst_n=0 at the next edge → rvalid_o stays 0, state returns to IDLE.
